cpu_trace_checker: RTL and testbench

Parametrised streaming checker for CPU write-back trace records, one ASCII character per clock. Classifies each record as a register write or a memory write, or rejects it as malformed. On each well-formed record it also flags semantic faults: PC range or alignment, address alignment, and register index. It sits on the simulation and debug side of the CPU, fed by the trace UART or a testbench, and keeps a saturating count of accepted records.

---
 rtl/cpu_trace_checker.sv | 247 ++++++++++++++++++++++++
 tb/tb_cpu_trace_checker.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_checker.sv
// cpu_trace_checker: streaming parser/checker for CPU write-back trace
// records, one ASCII character per clock.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   char          in   8-bit ASCII character, sampled every rising edge
//   format_type   out  2-bit one-cycle pulse: 01 register write, 10 memory write
//   error_code    out  3-bit, valid with format_type:
//                      bit0 PC out of range/unaligned, bit1 address unaligned,
//                      bit2 register index > 31
//   record_count  out  CNT_W saturating count of accepted records
module cpu_trace_checker #(
   parameter int          TIME_DIGITS  = 4,
   parameter int          PC_DIGITS    = 8,
   parameter int          ADDR_DIGITS  = 8,
   parameter int          DATA_DIGITS  = 8,
   parameter int          GRF_DIGITS   = 4,
   parameter int          HEX_UPPER_OK = 1,
   parameter logic [31:0] PC_MIN       = 32'h0000_3000,
   parameter logic [31:0] PC_MAX       = 32'h0000_6ffc,
   parameter int          CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       char,
   output logic [1:0]       format_type,
   output logic [2:0]       error_code,
   output logic [CNT_W-1:0] record_count
);

   // Wide enough for any single field's digit count.
   localparam int CW = $clog2(TIME_DIGITS + PC_DIGITS + ADDR_DIGITS
                              + DATA_DIGITS + GRF_DIGITS + 1);

   localparam logic [CW-1:0] TN = CW'(TIME_DIGITS);
   localparam logic [CW-1:0] PN = CW'(PC_DIGITS);
   localparam logic [CW-1:0] AN = CW'(ADDR_DIGITS);
   localparam logic [CW-1:0] DN = CW'(DATA_DIGITS);
   localparam logic [CW-1:0] GN = CW'(GRF_DIGITS);

   localparam logic [1:0] T_REG = 2'b01;
   localparam logic [1:0] T_MEM = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE, S_TIME, S_PC, S_COLON, S_SP1, S_GRF, S_ADDR,
      S_SP2, S_EQ, S_SP3, S_DATA, S_TAIL, S_ERR
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    dcnt_q, dcnt_d;
   logic [31:0]      pc_q, pc_d;
   // Only the address's alignment is ever observable.
   logic [1:0]       ad_q, ad_d;
   logic [7:0]       grf_q, grf_d;
   logic [1:0]       typ_q, typ_d;
   logic [1:0]       ft_q, ft_d;
   logic [2:0]       ec_q, ec_d;
   logic [CNT_W-1:0] rcnt_q, rcnt_d;

   logic        is_dec, is_low, is_up, is_hex;
   logic        is_sp;
   logic [3:0]  nib;
   logic [11:0] gmul;
   logic [7:0]  gsat;
   logic        pc_bad;
   logic        emit;

   // ASCII '0'-'9', 'a'-'f', 'A'-'F' share the low nibble trick:
   // letters carry value-9 in their low nibble.
   always_comb begin
      is_dec = (char >= "0") && (char <= "9");
      is_low = (char >= "a") && (char <= "f");
      is_up  = (HEX_UPPER_OK != 0) && (char >= "A") && (char <= "F");
      is_hex = is_dec || is_low || is_up;
      is_sp  = (char == " ");
      nib    = is_dec ? char[3:0] : char[3:0] + 4'd9;
   end

   // Decimal register index, saturating at 255.
   always_comb begin
      gmul = 12'(grf_q) * 12'd10 + 12'(nib);
      gsat = (gmul > 12'd255) ? 8'd255 : gmul[7:0];
   end

   assign pc_bad = (pc_q < PC_MIN) || (pc_q > PC_MAX)
                || (pc_q[1:0] != 2'b00);

   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      pc_d    = pc_q;
      ad_d    = ad_q;
      grf_d   = grf_q;
      typ_d   = typ_q;
      ft_d    = 2'b00;
      ec_d    = 3'b000;
      rcnt_d  = rcnt_q;
      emit    = 1'b0;

      if (char == "^") begin
         // Restart from any state, even mid-record.
         state_d = S_TIME;
         dcnt_d  = '0;
         pc_d    = '0;
         ad_d    = '0;
         grf_d   = '0;
         typ_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE, S_ERR: state_d = state_q;
            S_TIME: begin
               if (is_dec && dcnt_q < TN) begin
                  dcnt_d = dcnt_q + 1'b1;
               end else if (char == "@" && dcnt_q != '0) begin
                  state_d = S_PC;
                  dcnt_d  = '0;
               end else begin
                  state_d = S_ERR;
               end
            end
            S_PC: begin
               if (is_hex && dcnt_q < PN) begin
                  dcnt_d = dcnt_q + 1'b1;
                  pc_d   = {pc_q[27:0], nib};
               end else if (char == ":" && dcnt_q == PN) begin
                  state_d = S_COLON;
                  dcnt_d  = '0;
               end else begin
                  state_d = S_ERR;
               end
            end
            S_COLON, S_SP1: begin
               if (is_sp) begin
                  state_d = S_SP1;
               end else if (char == "$") begin
                  state_d = S_GRF;
                  typ_d   = T_REG;
               end else if (char == "*") begin
                  state_d = S_ADDR;
                  typ_d   = T_MEM;
               end else begin
                  state_d = S_ERR;
               end
            end
            S_GRF: begin
               if (is_dec && dcnt_q < GN) begin
                  dcnt_d = dcnt_q + 1'b1;
                  grf_d  = gsat;
               end else if (is_sp && dcnt_q != '0) begin
                  state_d = S_SP2;
                  dcnt_d  = '0;
               end else if (char == "<" && dcnt_q != '0) begin
                  state_d = S_EQ;
                  dcnt_d  = '0;
               end else begin
                  state_d = S_ERR;
               end
            end
            S_ADDR: begin
               if (is_hex && dcnt_q < AN) begin
                  dcnt_d = dcnt_q + 1'b1;
                  ad_d   = nib[1:0];
               end else if (is_sp && dcnt_q == AN) begin
                  state_d = S_SP2;
                  dcnt_d  = '0;
               end else if (char == "<" && dcnt_q == AN) begin
                  state_d = S_EQ;
                  dcnt_d  = '0;
               end else begin
                  state_d = S_ERR;
               end
            end
            S_SP2: begin
               if (char == "<") state_d = S_EQ;
               else if (!is_sp) state_d = S_ERR;
            end
            S_EQ: begin
               state_d = (char == "=") ? S_SP3 : S_ERR;
            end
            S_SP3: begin
               if (is_hex) begin
                  state_d = S_DATA;
                  dcnt_d  = {{(CW-1){1'b0}}, 1'b1};
               end else if (!is_sp) begin
                  state_d = S_ERR;
               end
            end
            S_DATA: begin
               if (is_hex && dcnt_q < DN) begin
                  dcnt_d = dcnt_q + 1'b1;
               end else if (is_sp && dcnt_q == DN) begin
                  state_d = S_TAIL;
               end else if (char == "#" && dcnt_q == DN) begin
                  emit = 1'b1;
               end else begin
                  state_d = S_ERR;
               end
            end
            S_TAIL: begin
               if (char == "#") emit = 1'b1;
               else if (!is_sp) state_d = S_ERR;
            end
            default: state_d = S_ERR;
         endcase
      end

      if (emit) begin
         state_d = S_IDLE;
         dcnt_d  = '0;
         ft_d    = typ_q;
         ec_d[0] = pc_bad;
         ec_d[1] = (typ_q == T_MEM) && (ad_q != 2'b00);
         ec_d[2] = (typ_q == T_REG) && (grf_q > 8'd31);
         if (rcnt_q != '1) rcnt_d = rcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         dcnt_q  <= '0;
         pc_q    <= '0;
         ad_q    <= '0;
         grf_q   <= '0;
         typ_q   <= '0;
         ft_q    <= '0;
         ec_q    <= '0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         pc_q    <= pc_d;
         ad_q    <= ad_d;
         grf_q   <= grf_d;
         typ_q   <= typ_d;
         ft_q    <= ft_d;
         ec_q    <= ec_d;
         rcnt_q  <= rcnt_d;
      end
   end

   assign format_type  = ft_q;
   assign error_code   = ec_q;
   assign record_count = rcnt_q;

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Testbench for cpu_trace_checker: two instances (upper-case hex on/off,
// wide and 2-bit counters) fed one character stream, scoreboard checked.
module tb_cpu_trace_checker;

   localparam int TD = 4;
   localparam int PD = 8;
   localparam int AD = 8;
   localparam int DD = 8;
   localparam int GD = 4;
   localparam logic [31:0] PMIN = 32'h0000_3000;
   localparam logic [31:0] PMAX = 32'h0000_6ffc;

   typedef struct {
      int         idx;
      logic [1:0] f;
      logic [2:0] e;
      int         c;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  ch;
   logic [1:0]  ft0, ft1;
   logic [2:0]  ec0, ec1;
   logic [15:0] rc0;
   logic [1:0]  rc1;

   exp_t q0[$];
   exp_t q1[$];
   int   exp_cnt[2];
   int   mcnt[2];
   int   cur_idx;
   int   gidx;
   int   ntests;
   int   nfail;

   string HXL  = "0123456789abcdef";
   string HXU  = "0123456789ABCDEF";
   string ALPH = "0123456789abcfABF $*<=#@:^xg";

   always #5 clk = ~clk;

   cpu_trace_checker #(.HEX_UPPER_OK(1), .CNT_W(16)) u0 (
      .clk(clk), .reset(reset), .char(ch),
      .format_type(ft0), .error_code(ec0), .record_count(rc0)
   );

   cpu_trace_checker #(.HEX_UPPER_OK(0), .CNT_W(2)) u1 (
      .clk(clk), .reset(reset), .char(ch),
      .format_type(ft1), .error_code(ec1), .record_count(rc1)
   );

   function automatic bit is_dec(byte c);
      return (c >= "0") && (c <= "9");
   endfunction

   function automatic bit is_hex(byte c, bit up);
      return is_dec(c) || (c >= "a" && c <= "f")
          || (up && c >= "A" && c <= "F");
   endfunction

   function automatic logic [3:0] hv(byte c);
      if (is_dec(c)) return 4'(c - 8'd48);
      if (c >= "a") return 4'(c - 8'd87);
      return 4'(c - 8'd55);
   endfunction

   // Reference: does record r (from '^' through its first '#') match
   // the grammar, and if so what type and error code does it carry.
   function automatic bit model(input string r, input bit up,
                                output logic [1:0] f,
                                output logic [2:0] e);
      int p, n, L;
      logic [31:0] pc, ad;
      longint g;
      L = r.len(); p = 1; f = 0; e = 0; pc = 0; ad = 0; g = 0;
      n = 0;
      while (p < L && is_dec(r.getc(p))) begin p++; n++; end
      if (n < 1 || n > TD || p >= L || r.getc(p) != "@") return 0;
      p++; n = 0;
      while (p < L && is_hex(r.getc(p), up)) begin
         pc = {pc[27:0], hv(r.getc(p))}; p++; n++;
      end
      if (n != PD || p >= L || r.getc(p) != ":") return 0;
      p++;
      while (p < L && r.getc(p) == " ") p++;
      if (p >= L) return 0;
      if (r.getc(p) == "$") begin
         f = 2'b01; p++; n = 0;
         while (p < L && is_dec(r.getc(p))) begin
            g = g * 10 + longint'(r.getc(p) - 8'd48); p++; n++;
         end
         if (n < 1 || n > GD) return 0;
      end else if (r.getc(p) == "*") begin
         f = 2'b10; p++; n = 0;
         while (p < L && is_hex(r.getc(p), up)) begin
            ad = {ad[27:0], hv(r.getc(p))}; p++; n++;
         end
         if (n != AD) return 0;
      end else begin
         return 0;
      end
      while (p < L && r.getc(p) == " ") p++;
      if (p + 1 >= L || r.getc(p) != "<" || r.getc(p+1) != "=") return 0;
      p += 2;
      while (p < L && r.getc(p) == " ") p++;
      n = 0;
      while (p < L && is_hex(r.getc(p), up)) begin p++; n++; end
      if (n != DD) return 0;
      while (p < L && r.getc(p) == " ") p++;
      if (p != L - 1 || r.getc(p) != "#") return 0;
      e[0] = (pc < PMIN) || (pc > PMAX) || (pc % 4 != 0);
      e[1] = (f == 2'b10) && (ad % 4 != 0);
      e[2] = (f == 2'b01) && (g > 31);
      return 1;
   endfunction

   function automatic string hexs(logic [31:0] v, int n, bit up);
      string s = "";
      int nb;
      for (int k = n - 1; k >= 0; k--) begin
         nb = (k < 8) ? int'(v[4*k +: 4]) : int'($urandom_range(0, 15));
         s = {s, up ? HXU.substr(nb, nb) : HXL.substr(nb, nb)};
      end
      return s;
   endfunction

   function automatic string decs(int n);
      string s = "";
      int d;
      for (int k = 0; k < n; k++) begin
         d = $urandom_range(0, 9);
         s = {s, HXL.substr(d, d)};
      end
      return s;
   endfunction

   function automatic string sp();
      int n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      string s = "";
      for (int k = 0; k < n; k++) s = {s, " "};
      return s;
   endfunction

   function automatic int fuzz_len(int n);
      if ($urandom_range(0, 15) != 0) return n;
      return ($urandom_range(0, 1) == 1) ? n + 1 : n - 1;
   endfunction

   function automatic string gen_record();
      string r;
      int n, k;
      logic [31:0] pc, a;
      int g;
      n = $urandom_range(1, TD);
      if ($urandom_range(0, 15) == 0) n = ($urandom_range(0, 1) == 1) ? 0 : TD + 1;
      r = {"^", decs(n), "@"};
      case ($urandom_range(0, 5))
         0, 1: pc = PMIN + 4 * $urandom_range(0, (PMAX - PMIN) / 4);
         2: pc = PMIN + 4 * $urandom_range(0, 100) + $urandom_range(1, 3);
         3: pc = $urandom_range(0, PMIN - 1);
         4: pc = PMAX + 1 + $urandom_range(0, 4096);
         default: begin
            k = $urandom_range(0, 3);
            pc = (k == 0) ? PMIN : (k == 1) ? PMAX : (k == 2) ? PMAX + 4 : PMIN - 4;
         end
      endcase
      r = {r, hexs(pc, fuzz_len(PD), $urandom_range(0, 5) == 0), ":", sp()};
      if ($urandom_range(0, 1) == 1) begin
         case ($urandom_range(0, 3))
            0, 1: g = $urandom_range(0, 31);
            2: g = $urandom_range(32, 300);
            default: g = $urandom_range(0, 99999);
         endcase
         r = {r, "$", $sformatf("%0d", g), sp()};
      end else begin
         a = $urandom;
         r = {r, "*", hexs(a, fuzz_len(AD), $urandom_range(0, 5) == 0), sp()};
      end
      n = DD;
      if ($urandom_range(0, 11) == 0) n = ($urandom_range(0, 1) == 1) ? DD - 1 : DD + 2;
      r = {r, "<=", sp(), hexs($urandom, n, $urandom_range(0, 3) == 0), sp(), "#"};
      if ($urandom_range(0, 7) == 0) begin
         k = $urandom_range(0, ALPH.len() - 1);
         r.putc($urandom_range(1, r.len() - 1), ALPH.getc(k));
      end
      if ($urandom_range(0, 11) == 0) r = r.substr(0, $urandom_range(1, r.len() - 2));
      return r;
   endfunction

   task automatic cmp(string nm, int act, int req);
      ntests++;
      if (act != req) begin
         nfail++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   // Expected pulses are pushed for the whole stream before it is driven.
   task automatic send_str(string s, bit term);
      int L, j;
      string seg;
      logic [1:0] f;
      logic [2:0] e;
      exp_t x;
      if (term) s = {s, "x"};
      L = s.len();
      for (int i = 0; i < L; i++) begin
         if (s.getc(i) == "^") begin
            j = i + 1;
            while (j < L && s.getc(j) != "^" && s.getc(j) != "#") j++;
            if (j < L && s.getc(j) == "#") begin
               seg = s.substr(i, j);
               for (int d = 0; d < 2; d++) begin
                  if (model(seg, d == 0, f, e)) begin
                     if (mcnt[d] < ((d == 0) ? 65535 : 3)) mcnt[d]++;
                     x.idx = gidx + j; x.f = f; x.e = e; x.c = mcnt[d];
                     if (d == 0) q0.push_back(x);
                     else q1.push_back(x);
                  end
               end
            end
         end
      end
      for (int i = 0; i < L; i++) begin
         @(negedge clk);
         ch = s.getc(i);
         cur_idx = gidx + i;
      end
      gidx += L;
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         ch = " ";
         cur_idx = -1;
      end
   endtask

   task automatic mon(int d, logic [1:0] f, logic [2:0] e, logic [31:0] rc);
      exp_t x;
      bit hit = 0;
      if (d == 0 && q0.size() > 0 && q0[0].idx == cur_idx) begin
         x = q0.pop_front(); hit = 1;
      end
      if (d == 1 && q1.size() > 0 && q1[0].idx == cur_idx) begin
         x = q1.pop_front(); hit = 1;
      end
      ntests++;
      if (hit) begin
         exp_cnt[d] = x.c;
         if (f !== x.f || e !== x.e || rc !== 32'(x.c)) begin
            nfail++;
            $display("FAIL pulse dut%0d idx %0d: got ft=%0d ec=%0d cnt=%0d, required ft=%0d ec=%0d cnt=%0d",
                     d, cur_idx, f, e, rc, x.f, x.e, x.c);
         end
      end else if (f !== 2'b00 || e !== 3'b000 || rc !== 32'(exp_cnt[d])) begin
         nfail++;
         $display("FAIL quiet dut%0d idx %0d: got ft=%0d ec=%0d cnt=%0d, required ft=0 ec=0 cnt=%0d",
                  d, cur_idx, f, e, rc, exp_cnt[d]);
      end
   endtask

   always begin
      @(posedge clk);
      #1;
      mon(0, ft0, ec0, 32'(rc0));
      mon(1, ft1, ec1, 32'(rc1));
   end

   task automatic chk_zero(string nm);
      cmp({nm, " ft0"}, int'(ft0), 0);
      cmp({nm, " ec0"}, int'(ec0), 0);
      cmp({nm, " rc0"}, int'(rc0), 0);
      cmp({nm, " ft1"}, int'(ft1), 0);
      cmp({nm, " ec1"}, int'(ec1), 0);
      cmp({nm, " rc1"}, int'(rc1), 0);
   endtask

   initial begin
      string s;
      ntests = 0; nfail = 0; gidx = 0; cur_idx = -1;
      exp_cnt[0] = 0; exp_cnt[1] = 0; mcnt[0] = 0; mcnt[1] = 0;
      reset = 1'b1;
      ch = " ";
      #1;
      chk_zero("reset");
      @(negedge clk);
      reset = 1'b0;
      idle(2);

      send_str({"^242@00003034: $31 <= 12345678#",
                "^338@00003130: *00000088 <= ffffb528#",
                "^338@00003130: *00000088 <= ffffb52#",
                "^338@00003130: *00000088 <= ffffb52800#",
                "^1@00002ffe: *00000089 <=   Ab123215 #",
                "^7@00003000: $32<=00000000#",
                "^7@00003000: $12345<=00000000#",
                "^242@0000^5@00003000: $0 <= 00000000#"}, 1);
      idle(3);

      send_str("^242@00003034: $31 <= 12345678#", 1);
      send_str("^5@00003000: $1 <= 1234", 0);
      @(negedge clk);
      #2;
      cur_idx = -1;
      mcnt[0] = 0; mcnt[1] = 0;
      exp_cnt[0] = 0; exp_cnt[1] = 0;
      reset = 1'b1;
      #1;
      chk_zero("midreset");
      @(negedge clk);
      reset = 1'b0;
      send_str("5678#", 1);
      send_str("^9@00003004: *00000010 <= 00000000#", 1);
      idle(2);

      for (int t = 0; t < 40; t++) begin
         s = "";
         for (int r = 0; r < 5; r++) begin
            s = {s, gen_record()};
            if ($urandom_range(0, 3) == 0) s = {s, " x "};
         end
         send_str(s, 1);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(4);

      cmp("q0 drained", q0.size(), 0);
      cmp("q1 drained", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
